// File: rtl/lsm_pkg.sv
// Shared Q-format widths, feeder FSM states and sample types for the Longstaff-Schwartz regression datapath.
package lsm_pkg;
    localparam int X_W    = 16;
    localparam int Y_W    = 16;
    localparam int FRAC_W = 15;

    typedef logic [X_W-1:0] price_t;
    typedef logic [Y_W-1:0] cash_t;
    typedef logic [X_W:0]   price_sq_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        READ,
        DRAIN,
        DONE
    } feeder_state_t;
endpackage

// File: rtl/lsm_q15_square.sv
// Combinational unsigned fixed-point squarer; drops the FRAC low product bits by truncation.
module lsm_q15_square #(
    parameter int W    = lsm_pkg::X_W,
    parameter int FRAC = lsm_pkg::FRAC_W
) (
    input  logic [W-1:0]        a,
    output logic [2*W-FRAC-1:0] sq
);
    logic [2*W-1:0]  prod;
    logic [FRAC-1:0] unused_frac;

    assign prod        = {{W{1'b0}}, a} * {{W{1'b0}}, a};
    assign sq          = prod[2*W-1:FRAC];
    assign unused_frac = prod[FRAC-1:0];
endmodule

// File: rtl/lsm_sample_feeder.sv
// Streams in-the-money (price, cashflow) samples from path memory into the regression accumulators.
// Build option: define LSM_FEEDER_ITM_FILTER_EN to keep only paths with price < strike.
module lsm_sample_feeder
    import lsm_pkg::*;
#(
    parameter int N_PATHS = 1024,
    parameter int ADDR_W  = 10,
    parameter int X_W     = lsm_pkg::X_W,
    parameter int Y_W     = lsm_pkg::Y_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              go,
    input  logic [X_W-1:0]    strike,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [X_W-1:0]    mem_price,
    input  logic [Y_W-1:0]    mem_cash,
    output logic              acc_clear,
    output logic              out_valid,
    output logic [X_W-1:0]    out_xi,
    output logic [X_W:0]      out_xi2,
    output logic [Y_W-1:0]    out_yi,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   itm_count,
    output logic [2:0]        dbg_state
);
    // out_valid is a strobe with no back-pressure: downstream accumulates every
    // cycle it is high, exactly once, and never stalls the feeder.
    feeder_state_t     state, state_nx;
    logic [ADDR_W-1:0] rd_addr;
    logic              last_addr;
    logic              drain_cnt;
    logic [X_W-1:0]    strike_q;
    logic              rd_vld_d1;
    logic              is_itm;
    logic [X_W:0]      price_sq;

    assign last_addr = (rd_addr == ADDR_W'(N_PATHS - 1));
    assign mem_addr  = rd_addr;
    assign dbg_state = state;

`ifdef LSM_FEEDER_ITM_FILTER_EN
    assign is_itm = (mem_price < strike_q);
`else
    logic unused_strike;
    assign is_itm        = 1'b1;
    assign unused_strike = ^strike_q;
`endif

    lsm_q15_square #(
        .W    (X_W),
        .FRAC (X_W - 1)
    ) u_square (
        .a  (mem_price),
        .sq (price_sq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        mem_rd_en = 1'b0;
        acc_clear = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE:  if (go) state_nx = CLEAR;
            CLEAR: begin
                acc_clear = 1'b1;
                busy      = 1'b1;
                state_nx  = READ;
            end
            READ: begin
                mem_rd_en = 1'b1;
                busy      = 1'b1;
                if (last_addr) state_nx = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_cnt) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One stage for the memory read, one for the qualify register: address at t, sample at t+2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr   <= '0;
            drain_cnt <= 1'b0;
            strike_q  <= '0;
            rd_vld_d1 <= 1'b0;
            out_valid <= 1'b0;
            out_xi    <= '0;
            out_xi2   <= '0;
            out_yi    <= '0;
            itm_count <= '0;
        end else begin
            rd_vld_d1 <= (state == READ);
            out_valid <= rd_vld_d1 && is_itm;
            if (rd_vld_d1 && is_itm) begin
                out_xi  <= mem_price;
                out_xi2 <= price_sq;
                out_yi  <= mem_cash;
            end
            if (out_valid) itm_count <= itm_count + (ADDR_W + 1)'(1);
            case (state)
                IDLE:  if (go) strike_q <= strike;
                CLEAR: begin
                    rd_addr   <= '0;
                    itm_count <= '0;
                end
                READ: begin
                    if (!last_addr) rd_addr <= rd_addr + ADDR_W'(1);
                    drain_cnt <= 1'b0;
                end
                DRAIN:   drain_cnt <= 1'b1;
                default: ;
            endcase
        end
    end
endmodule
